// File: rtl/yolo_pool_pkg.sv
// yolo_pool_pkg: shared pooling defaults, counter widths and window indexing helpers
package yolo_pool_pkg;
   localparam int K_DEF     = 2;
   localparam int WIDTH_DEF = 8;
   localparam int IMG_W_DEF = 16;
   localparam int IMG_H_DEF = 16;
   localparam int COL_W     = $clog2(IMG_W_DEF);
   localparam int ROW_W     = $clog2(IMG_H_DEF);
   function automatic int cnt_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   function automatic int win_idx(input int r, input int c, input int k = K_DEF);
      return r * k + c;
   endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: K-1 row store, one write and one same-column read per row each cycle
module pool_line_buffer
   import yolo_pool_pkg::*;
#(
   parameter int ROWS  = K_DEF - 1,
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = IMG_W_DEF,
   parameter int AW    = COL_W
)(
   input  logic                       clk,
   input  logic [ROWS-1:0]            wr_en,
   input  logic [AW-1:0]              addr,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [ROWS-1:0][WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [ROWS][DEPTH];
   // Asynchronous read returns the pre-write contents when the same column is written this cycle
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign rd_data[r] = mem[r][addr];
      always_ff @(posedge clk)
         if (wr_en[r]) mem[r][addr] <= wr_data;
   end
endmodule

// File: rtl/pool_window_gen.sv
// pool_window_gen: raster pixel stream to non-overlapping KxK windows (stride K)
module pool_window_gen
   import yolo_pool_pkg::*;
#(
   parameter int K     = K_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_pixel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH*K*K-1:0]   out_window_flat,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   frame_done
);
   localparam int CW    = cnt_w(IMG_W);
   localparam int RW    = cnt_w(IMG_H);
   localparam int PW    = cnt_w(K);
   localparam int W_LIM = (IMG_W / K) * K;
   localparam int H_LIM = (IMG_H / K) * K;
   logic [CW-1:0]                   col_cnt;
   logic [RW-1:0]                   row_cnt;
   logic [PW-1:0]                   col_ph, row_ph;
   logic [K-1:0][K-2:0][WIDTH-1:0]  sh;
   logic [K-2:0][WIDTH-1:0]         rd;
   logic [K-2:0]                    wr_en;
   logic [WIDTH*K*K-1:0]            win;
   logic                            xfer, col_last, row_last, emit;
   assign in_ready = !out_valid || out_ready;
   assign xfer     = in_valid && in_ready;
   assign col_last = col_cnt == CW'(IMG_W - 1);
   assign row_last = row_cnt == RW'(IMG_H - 1);
   assign emit     = col_ph == PW'(K - 1) && row_ph == PW'(K - 1)
                     && int'(col_cnt) < W_LIM && int'(row_cnt) < H_LIM;
   // Window column K-1 comes straight from the line-buffer read and the incoming pixel
   for (genvar r = 0; r < K; r++) begin : g_r
      for (genvar c = 0; c < K; c++) begin : g_c
         if (c < K - 1) begin : g_sh
            assign win[WIDTH*win_idx(r, c, K) +: WIDTH] = sh[r][c];
         end else if (r < K - 1) begin : g_rd
            assign win[WIDTH*win_idx(r, c, K) +: WIDTH] = rd[r];
         end else begin : g_px
            assign win[WIDTH*win_idx(r, c, K) +: WIDTH] = in_pixel;
         end
      end
   end
   for (genvar r = 0; r < K - 1; r++) begin : g_wr
      assign wr_en[r] = xfer && row_ph == PW'(r);
   end
   pool_line_buffer #(
      .ROWS(K - 1), .WIDTH(WIDTH), .DEPTH(IMG_W), .AW(CW)
   ) u_line_buffer (
      .clk(clk), .wr_en(wr_en), .addr(col_cnt), .wr_data(in_pixel), .rd_data(rd)
   );
   always_ff @(posedge clk)
      if (xfer)
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K - 1; c++)
               sh[r][c] <= win[WIDTH*win_idx(r, c + 1, K) +: WIDTH];
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt         <= '0;
         row_cnt         <= '0;
         col_ph          <= '0;
         row_ph          <= '0;
         out_valid       <= 1'b0;
         out_window_flat <= '0;
         frame_done      <= 1'b0;
      end else begin
         frame_done <= xfer && col_last && row_last;
         if (xfer) begin
            col_cnt <= col_last ? '0 : col_cnt + 1'b1;
            col_ph  <= (col_last || col_ph == PW'(K - 1)) ? '0 : col_ph + 1'b1;
            if (col_last) begin
               row_cnt <= row_last ? '0 : row_cnt + 1'b1;
               row_ph  <= (row_last || row_ph == PW'(K - 1)) ? '0 : row_ph + 1'b1;
            end
         end
         // A freshly loaded window takes priority over the consumer draining the old one
         if (xfer && emit) begin
            out_valid       <= 1'b1;
            out_window_flat <= win;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: directed and random checks of pool_window_gen against a window-list model
module tb_pool_window_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_pixel = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  sel = '0;
   logic [2:0]  in_ready_v, out_valid_v, frame_done_v;
   logic [31:0] win_v [3];
   logic        in_ready_m, out_valid_m, frame_done_m;
   logic [31:0] win_m;
   int          total = 0, bad = 0, pi = 0, nwin = 0, fd_cnt = 0;
   logic [31:0] first_win, last_win;
   logic [7:0]  pix [$];
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   pool_window_gen #(.K(2), .WIDTH(8), .IMG_W(4), .IMG_H(4)) u4 (
      .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid && sel == 2'd0),
      .in_ready(in_ready_v[0]), .out_window_flat(win_v[0]), .out_valid(out_valid_v[0]),
      .out_ready(out_ready && sel == 2'd0), .frame_done(frame_done_v[0]));
   pool_window_gen #(.K(2), .WIDTH(8), .IMG_W(5), .IMG_H(5)) u5 (
      .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid && sel == 2'd1),
      .in_ready(in_ready_v[1]), .out_window_flat(win_v[1]), .out_valid(out_valid_v[1]),
      .out_ready(out_ready && sel == 2'd1), .frame_done(frame_done_v[1]));
   pool_window_gen #(.K(2), .WIDTH(8), .IMG_W(8), .IMG_H(8)) u8 (
      .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid && sel == 2'd2),
      .in_ready(in_ready_v[2]), .out_window_flat(win_v[2]), .out_valid(out_valid_v[2]),
      .out_ready(out_ready && sel == 2'd2), .frame_done(frame_done_v[2]));

   assign in_ready_m   = in_ready_v[sel];
   assign out_valid_m  = out_valid_v[sel];
   assign frame_done_m = frame_done_v[sel];
   assign win_m        = win_v[sel];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Expected windows of one w x h frame, in raster order of window position
   task automatic model(input int w, input int h, input int base);
      for (int wr = 0; wr < h / 2; wr++)
         for (int wc = 0; wc < w / 2; wc++) begin
            logic [31:0] f;
            for (int r = 0; r < 2; r++)
               for (int c = 0; c < 2; c++)
                  f[8*(r*2+c) +: 8] = pix[base + (wr*2 + r)*w + wc*2 + c];
            exp_q.push_back(f);
         end
   endtask

   function automatic int smax(input logic [31:0] f);
      int m = -128;
      for (int i = 0; i < 4; i++)
         if (int'($signed(f[8*i +: 8])) > m) m = int'($signed(f[8*i +: 8]));
      return m;
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid_m, 0);
      chk("rst_window", win_m, 0);
      chk("rst_frame_done", frame_done_m, 0);
      chk("rst_in_ready", in_ready_m, 1);
      rst = 1'b0;
      pi = 0; nwin = 0; fd_cnt = 0;
      pix.delete(); exp_q.delete();
   endtask

   task automatic run(input bit rnd, input int budget);
      int cyc = 0;
      logic [31:0] want;
      while ((pi < pix.size() || exp_q.size() != 0) && cyc < budget) begin
         in_valid  = pi < pix.size() && (!rnd || $urandom_range(3) != 0);
         in_pixel  = in_valid ? pix[pi] : 8'($urandom);
         out_ready = !rnd || $urandom_range(2) != 0;
         #1;
         if (out_valid_m && out_ready) begin
            chk("window_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               want = exp_q.pop_front();
               chk("window", win_m, want);
               if (nwin == 0) first_win = win_m;
               last_win = win_m;
               nwin++;
            end
         end
         if (in_valid && in_ready_m) pi++;
         @(posedge clk); #1;
         if (frame_done_m) fd_cnt++;
         cyc++;
      end
      chk("run_complete", 64'(pi == pix.size() && exp_q.size() == 0), 1);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("no_extra_window", out_valid_m, 0);
   endtask

   initial begin
      // 1: 4x4 raster 0..15, full throughput
      sel = 2'd0;
      do_reset();
      for (int i = 0; i < 16; i++) pix.push_back(8'(i));
      model(4, 4, 0);
      run(1'b0, 200);
      chk("t1_first", first_win, 32'h05040100);
      chk("t1_last", last_win, 32'h0f0e0b0a);
      chk("t1_count", nwin, 4);
      chk("t1_frame_done", fd_cnt, 1);
      // 2: backpressure after the first window
      do_reset();
      for (int i = 0; i < 16; i++) pix.push_back(8'(i));
      model(4, 4, 0);
      for (int i = 0; i < 20 && !out_valid_m; i++) begin
         in_valid = 1'b1; in_pixel = pix[pi];
         #1;
         if (in_ready_m) pi++;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_pixel = pix[pi];
         #1;
         chk("t2_hold_valid", out_valid_m, 1);
         chk("t2_hold_window", win_m, 32'h05040100);
         chk("t2_hold_in_ready", in_ready_m, 0);
         @(posedge clk); #1;
      end
      chk("t2_accepted", pi, 6);
      run(1'b0, 200);
      chk("t2_count", nwin, 4);
      chk("t2_frame_done", fd_cnt, 1);
      // 3: ragged 5x5
      sel = 2'd1;
      do_reset();
      for (int i = 0; i < 25; i++) pix.push_back(8'(i));
      model(5, 5, 0);
      run(1'b0, 200);
      chk("t3_first", first_win, 32'h06050100);
      chk("t3_last", last_win, 32'h12110d0c);
      chk("t3_count", nwin, 4);
      chk("t3_frame_done", fd_cnt, 1);
      // 4: signed pixels pass through untouched
      sel = 2'd0;
      do_reset();
      for (int i = 0; i < 16; i++) pix.push_back(8'($urandom));
      pix[0] = 8'h80; pix[1] = 8'hff; pix[4] = 8'h7f; pix[5] = 8'h00;
      model(4, 4, 0);
      run(1'b1, 400);
      chk("t4_signed", first_win, 32'h007fff80);
      chk("t4_max", 64'(smax(first_win)), 64'd127);
      // 5: reset mid-frame, then a clean frame
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_pixel = 8'(i);
         @(posedge clk); #1;
      end
      do_reset();
      for (int i = 0; i < 16; i++) pix.push_back(8'(i));
      model(4, 4, 0);
      run(1'b0, 200);
      chk("t5_first", first_win, 32'h05040100);
      chk("t5_count", nwin, 4);
      chk("t5_frame_done", fd_cnt, 1);
      // 6: three back-to-back random 8x8 frames with random gaps
      sel = 2'd2;
      do_reset();
      for (int i = 0; i < 192; i++) pix.push_back(8'($urandom));
      for (int f = 0; f < 3; f++) model(8, 8, f * 64);
      run(1'b1, 5000);
      chk("t6_count", nwin, 48);
      chk("t6_frame_done", fd_cnt, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
